// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for the multicycle RV32 subset datapath
// (lh, sh, andi, bne).
//
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB and drives every datapath
// enable. It handshakes with the instruction and data memories, aborts a
// stalled access after TIMEOUT_CYCLES wait cycles, and counts retired
// instructions.
//
// Optional feature, enabled by the macro ILLEGAL_TRAP_EN:
//   When defined, an illegal instruction seen in DECODE parks the FSM in TRAP.
//   TRAP holds every enable at 0 and is left only by reset. When undefined,
//   illegal instructions retire as NOPs.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode, funct3      instruction fields from the instruction register
//   alu_zero            ALU zero flag (rs1 - rs2 == 0)
//   imem_ready          instruction memory data valid
//   dmem_ready          data memory read data valid / write accepted
//   imem_req            instruction fetch request
//   ir_we, pc_we        instruction register / PC write strobes
//   pc_src              0: PC+4, 1: old_pc + branch immediate
//   alu_op              00 add, 01 sub, 10 and
//   alu_src_imm         ALU operand B = immediate
//   dmem_req, dmem_we   data memory request / write (sh)
//   reg_we, mem_to_reg  register write enable / writeback from memory
//   bus_err             one-cycle pulse after a memory timeout abort
//   retired             retired-instruction count (wraps)
//
// Timing notes
//   Level outputs (requests, ALU controls, reg_we, mem_to_reg, bus_err) are
//   registered from the next state. They are therefore 0 during reset, and
//   imem_req rises on the first clock edge after reset is released.
//   ir_we, pc_we and pc_src are completion strobes. They combine the
//   registered request (or state) with imem_ready/alu_zero in the same cycle.
//   This lets a single-cycle fetch or branch complete without a bubble.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8,
  parameter int RET_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             bus_err,
  output logic [RET_W-1:0] retired
);

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
`else
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
`endif

  typedef enum logic [2:0] {K_ILL, K_LH, K_SH, K_ANDI, K_BNE} kind_t;

  state_t          state, state_n;
  kind_t           kind, kind_dec, kind_n;
  logic [TO_W-1:0] tcnt;
  logic            i_wait, d_wait, tmo, retire, br_take;

  // Instruction class. The instruction register is valid from DECODE on.
  always_comb begin
    kind_dec = K_ILL;
    case ({opcode, funct3})
      {7'b0000011, 3'b001}: kind_dec = K_LH;
      {7'b0100011, 3'b001}: kind_dec = K_SH;
      {7'b0010011, 3'b111}: kind_dec = K_ANDI;
      {7'b1100011, 3'b001}: kind_dec = K_BNE;
      default:              kind_dec = K_ILL;
    endcase
  end

  // The class is latched on leaving DECODE. Outputs for EXEC are registered
  // on that same edge, so they use the live decode.
  assign kind_n = (state == DECODE) ? kind_dec : kind;

  // A wait cycle is a request without ready. Ready outside a request is
  // ignored because the requests are registered.
  assign i_wait = imem_req & ~imem_ready;
  assign d_wait = dmem_req & ~dmem_ready;
  // Abort at the end of wait cycle TIMEOUT_CYCLES. Ready in that same cycle
  // clears the wait, so ready wins.
  assign tmo    = (i_wait | d_wait) && (tcnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state;
    retire  = 1'b0;
    case (state)
      FETCH: begin
        if (imem_req && imem_ready) state_n = DECODE;
        else if (tmo)               state_n = FETCH;
      end
      DECODE: begin
        if (kind_dec == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          state_n = TRAP;
`else
          state_n = FETCH;
          retire  = 1'b1;
`endif
        end else begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        case (kind)
          K_LH, K_SH: state_n = MEM;
          K_ANDI:     state_n = WB;
          default: begin
            state_n = FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (dmem_req && dmem_ready) begin
          if (kind == K_SH) begin
            state_n = FETCH;
            retire  = 1'b1;
          end else begin
            state_n = WB;
          end
        end else if (tmo) begin
          state_n = FETCH;
        end
      end
      WB: begin
        state_n = FETCH;
        retire  = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: state_n = TRAP;
`endif
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      kind        <= K_ILL;
      tcnt        <= '0;
      retired     <= '0;
      imem_req    <= 1'b0;
      alu_op      <= 2'b00;
      alu_src_imm <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      reg_we      <= 1'b0;
      mem_to_reg  <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state <= state_n;
      kind  <= kind_n;
      // The counter is non-zero only while waiting. It therefore restarts
      // from 0 on every entry to FETCH or MEM.
      tcnt  <= ((i_wait || d_wait) && !tmo) ? tcnt + 1'b1 : '0;
      if (retire) retired <= retired + 1'b1;

      imem_req    <= (state_n == FETCH);
      alu_op      <= 2'b00;
      alu_src_imm <= 1'b0;
      if (state_n == EXEC) begin
        case (kind_n)
          K_ANDI: begin
            alu_op      <= 2'b10;
            alu_src_imm <= 1'b1;
          end
          K_BNE: begin
            alu_op      <= 2'b01;
            alu_src_imm <= 1'b0;
          end
          default: begin
            alu_op      <= 2'b00;
            alu_src_imm <= 1'b1;
          end
        endcase
      end
      dmem_req   <= (state_n == MEM);
      dmem_we    <= (state_n == MEM) && (kind_n == K_SH);
      reg_we     <= (state_n == WB);
      mem_to_reg <= (state_n == WB) && (kind_n == K_LH);
      bus_err    <= tmo;
    end
  end

  // Completion strobes. Both are 0 in reset: imem_req is 0 and the state is
  // FETCH.
  assign ir_we   = (state == FETCH) & imem_req & imem_ready;
  assign br_take = (state == EXEC) & (kind == K_BNE) & ~alu_zero;
  assign pc_we   = ir_we | br_take;
  assign pc_src  = br_take;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Each instruction is driven cycle by cycle with a chosen memory latency.
// The bench counts the enables it observes and compares the counts with
// per-instruction expectations. Those expectations are derived arithmetically
// from the instruction class and the latencies.
module tb_multicycle_ctrl;
  localparam int T = 255;

  logic        clk, rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alu_zero, imem_ready, dmem_ready;
  logic        imem_req, ir_we, pc_we, pc_src, alu_src_imm;
  logic        dmem_req, dmem_we, reg_we, mem_to_reg, bus_err;
  logic [1:0]  alu_op;
  logic [31:0] retired;
  logic [11:0] outs;

  int     total = 0;
  int     bad   = 0;
  longint exp_ret = 0;

  multicycle_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(8), .RET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .bus_err(bus_err), .retired(retired)
  );

  assign outs = {imem_req, ir_we, pc_we, pc_src, alu_op, alu_src_imm,
                 dmem_req, dmem_we, reg_we, mem_to_reg, bus_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("start_req", longint'(imem_req), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("rst_outs", longint'(outs), 0);
    chk("rst_ret", longint'(retired), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
    wait_start();
  endtask

  // Runs one instruction. Entry and exit are at a negedge with imem_req high.
  // di/dd: wait cycles before imem_ready/dmem_ready. dd >= T never answers.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input int di, input int dd, input bit az);
    bit is_lh, is_sh, is_andi, is_bne, is_ill, abt, done, gap, trap;
    int cyc, fw, dw, f, mem, tot, exec_op;
    int c_ir, c_pcwe, c_pcsrc, c_reg, c_m2r, c_dreq, c_dwe, c_berr, c_asi, c_aop;
    is_lh   = (op == 7'b0000011) && (f3 == 3'b001);
    is_sh   = (op == 7'b0100011) && (f3 == 3'b001);
    is_andi = (op == 7'b0010011) && (f3 == 3'b111);
    is_bne  = (op == 7'b1100011) && (f3 == 3'b001);
    is_ill  = !(is_lh || is_sh || is_andi || is_bne);
    trap = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap = is_ill;
`endif
    f   = di + 1;
    mem = (dd >= T) ? T : dd + 1;
    abt = (is_lh || is_sh) && (dd >= T);
    if (is_ill)       tot = f + 1;
    else if (is_bne)  tot = f + 2;
    else if (is_andi) tot = f + 3;
    else              tot = f + 2 + mem + ((is_lh && !abt) ? 1 : 0);

    opcode = op; funct3 = f3; alu_zero = az;
    cyc = 0; fw = 0; dw = 0; done = 1'b0; gap = 1'b0; exec_op = -1;
    c_ir = 0; c_pcwe = 0; c_pcsrc = 0; c_reg = 0; c_m2r = 0;
    c_dreq = 0; c_dwe = 0; c_berr = 0; c_asi = 0; c_aop = 0;
    while (!done && cyc < 600) begin
      if (cyc > 0 && gap && imem_req) begin
        done = 1'b1;
        c_berr += int'(bus_err);
      end else begin
        if (!imem_req) gap = 1'b1;
        // Outside a request the ready lines carry noise that must be ignored.
        imem_ready = imem_req ? (fw == di) : 1'($urandom_range(0, 1));
        if (imem_req) fw++;
        dmem_ready = dmem_req ? (dw == dd) : 1'($urandom_range(0, 1));
        if (dmem_req) dw++;
        #1;
        c_ir    += int'(ir_we);
        c_pcwe  += int'(pc_we);
        c_pcsrc += int'(pc_src);
        c_reg   += int'(reg_we);
        c_m2r   += int'(mem_to_reg);
        c_dreq  += int'(dmem_req);
        c_dwe   += int'(dmem_we);
        c_asi   += int'(alu_src_imm);
        c_aop   += int'(alu_op != 2'b00);
        if (cyc > 0) c_berr += int'(bus_err);
        if (cyc == di + 2) exec_op = int'(alu_op);
        cyc++;
        @(negedge clk);
      end
    end

    if (trap) begin
      chk("trap_hold", longint'(done), 0);
      chk("trap_ir", c_ir, 1);
      chk("trap_regwe", c_reg, 0);
      chk("trap_dreq", c_dreq, 0);
      chk("trap_ret", longint'(retired), exp_ret);
      do_reset();
    end else begin
      chk("done", longint'(done), 1);
      chk("cycles", cyc, tot);
      chk("ir_we", c_ir, 1);
      chk("pc_we", c_pcwe, (is_bne && !az) ? 2 : 1);
      chk("pc_src", c_pcsrc, (is_bne && !az) ? 1 : 0);
      chk("reg_we", c_reg, (is_andi || (is_lh && !abt)) ? 1 : 0);
      chk("mem_to_reg", c_m2r, (is_lh && !abt) ? 1 : 0);
      chk("dmem_req", c_dreq, (is_lh || is_sh) ? mem : 0);
      chk("dmem_we", c_dwe, is_sh ? mem : 0);
      chk("bus_err", c_berr, abt ? 1 : 0);
      chk("alu_src_imm", c_asi, (is_lh || is_sh || is_andi) ? 1 : 0);
      chk("alu_op_nz", c_aop, (is_andi || is_bne) ? 1 : 0);
      chk("exec_op", exec_op, is_ill ? -1 : is_andi ? 2 : is_bne ? 1 : 0);
      if (!abt) exp_ret++;
      chk("retired", longint'(retired), exp_ret);
    end
  endtask

  initial begin
    logic [6:0] ops [5];
    logic [2:0] f3s [5];
    int k, n, c_reg;
    ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b1100011, 7'b0110011};
    f3s = '{3'b001, 3'b001, 3'b111, 3'b001, 3'b000};
    rst_n = 1'b0; opcode = '0; funct3 = '0; alu_zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;

    do_reset();
    run_instr(7'b0010011, 3'b111, 0, 0, 1'b0);      // andi, 4 cycles
    run_instr(7'b0000011, 3'b001, 0, 3, 1'b0);      // lh, dmem 3 late, 8 cycles
    run_instr(7'b1100011, 3'b001, 0, 0, 1'b0);      // bne taken
    run_instr(7'b1100011, 3'b001, 0, 0, 1'b1);      // bne not taken
    run_instr(7'b0100011, 3'b001, 0, 1000, 1'b0);   // sh, never ready -> abort
    run_instr(7'b0100011, 3'b001, 1, T - 1, 1'b0);  // ready on last wait cycle
    run_instr(7'b0000011, 3'b001, 0, T, 1'b0);      // one cycle too late
    run_instr(7'b0000011, 3'b000, 0, 0, 1'b0);      // lh opcode, bad funct3
    run_instr(7'b0110011, 3'b000, 2, 0, 1'b0);      // R-type: illegal

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 4));
      run_instr(ops[k], f3s[k], int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    // Reset in the MEM state of an lh: outputs drop at once, with no write.
    opcode = 7'b0000011; funct3 = 3'b001; imem_ready = 1'b1; dmem_ready = 1'b0;
    n = 0; c_reg = 0;
    while (!dmem_req && n < 10) begin
      #1 c_reg += int'(reg_we);
      @(negedge clk);
      n++;
    end
    chk("mid_in_mem", longint'(dmem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_outs", longint'(outs), 0);
    chk("mid_ret", longint'(retired), 0);
    chk("mid_regwe", c_reg, 0);
    imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
    wait_start();
    run_instr(7'b0010011, 3'b111, 0, 0, 1'b0);
    chk("post_rst_ret", longint'(retired), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
